// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button conditioner.
// Each channel is synchronised, debounced and turned into one-cycle press/release
// pulses. Channels selected by REPEAT_MASK also emit auto-repeat press pulses
// while held.
// Ports:
//   clock    : system clock, all state on rising edge
//   reset    : asynchronous active-high reset, clears all state
//   in       : raw asynchronous button levels (1 = pressed)
//   level    : debounced level per channel
//   pressed  : 1-cycle pulse on accepted press and on each auto-repeat
//   released : 1-cycle pulse on accepted release

// One channel: synchroniser, debounce counter, edge pulses, optional repeat.
module button_channel #(
  parameter int SYNC_STAGES          = 2,
  parameter int STABLE_CYCLES        = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000,
  parameter bit REPEAT_EN            = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pressed,
  output logic released
);
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [CW-1:0]          cnt;
  logic [RW-1:0]          rcnt;
  logic                   rphase;   // 0: waiting for first repeat, 1: periodic phase
  logic                   toggle;
  logic                   rfire;

  assign sync_out = sync[SYNC_STAGES-1];
  // Level flips on the edge where the mismatch count would reach STABLE_CYCLES.
  assign toggle   = (sync_out != level) && (int'(cnt) + 1 == STABLE_CYCLES);
  // Repeat only while level stays high through this edge, so the release edge
  // itself can never produce a repeat pulse.
  assign rfire    = REPEAT_EN && level && !toggle &&
                    (int'(rcnt) + 1 == (rphase ? REPEAT_PERIOD_CYCLES : REPEAT_DELAY_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      cnt      <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
      rcnt     <= '0;
      rphase   <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      pressed  <= 1'b0;
      released <= 1'b0;

      if (sync_out == level) begin
        cnt <= '0;
      end else if (toggle) begin
        cnt   <= '0;
        level <= ~level;
        if (!level) pressed  <= 1'b1;
        else        released <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Counter is cleared on press, counts while held, restarts after each
      // repeat pulse and is held at zero while released; it never wraps.
      if (!REPEAT_EN || !level || toggle) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rfire) begin
        pressed <= 1'b1;
        rcnt    <= '0;
        rphase  <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int                  CHANNELS             = 5,
  parameter int                  SYNC_STAGES          = 2,
  parameter int                  STABLE_CYCLES        = 1000000,
  parameter int                  REPEAT_DELAY_CYCLES  = 50000000,
  parameter int                  REPEAT_PERIOD_CYCLES = 10000000,
  parameter logic [CHANNELS-1:0] REPEAT_MASK          = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released
);
  if (CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1 ||
      REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_param_err
    $error("button_conditioner: parameter below its minimum");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES         (SYNC_STAGES),
      .STABLE_CYCLES       (STABLE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
      .REPEAT_EN           (REPEAT_MASK[i])
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .raw     (in[i]),
      .level   (level[i]),
      .pressed (pressed[i]),
      .released(released[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized inputs
// compared cycle-by-cycle against a behavioural model (delay line, stable-run
// length, time-since-press arithmetic).
module tb_button_conditioner;
  localparam int         CH     = 2;
  localparam int         SYNC   = 2;
  localparam int         STABLE = 4;
  localparam int         RD     = 10;
  localparam int         RP     = 3;
  localparam logic [1:0] MASK   = 2'b01;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] in_s  = '0;
  logic [CH-1:0] level, pressed, released;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clock(clock), .reset(reset), .in(in_s),
    .level(level), .pressed(pressed), .released(released)
  );

  always #5 clock = ~clock;

  // Reference model: input seen by the debouncer is the raw input delayed by
  // SYNC samples; a level is accepted after STABLE consecutive mismatches;
  // repeats fire when time since press is RD, RD+RP, RD+2RP, ...
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_seen;
  logic [CH-1:0] e_lvl, e_p, e_r;
  int            run[CH];
  int            since[CH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back('0);
      e_lvl = '0; e_p = '0; e_r = '0;
      for (int c = 0; c < CH; c++) begin run[c] = 0; since[c] = 0; end
    end else begin
      m_seen = hist.pop_front();
      hist.push_back(in_s);
      e_p = '0; e_r = '0;
      for (int c = 0; c < CH; c++) begin
        if (m_seen[c] != e_lvl[c]) begin
          run[c]++;
          if (run[c] == STABLE) begin
            run[c]   = 0;
            e_lvl[c] = m_seen[c];
            if (m_seen[c]) begin e_p[c] = 1'b1; since[c] = 0; end
            else e_r[c] = 1'b1;
          end else if (e_lvl[c]) begin
            since[c]++;
            if (MASK[c] && (since[c] == RD || (since[c] > RD && (since[c] - RD) % RP == 0)))
              e_p[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
          if (e_lvl[c]) begin
            since[c]++;
            if (MASK[c] && (since[c] == RD || (since[c] > RD && (since[c] - RD) % RP == 0)))
              e_p[c] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    in_s = '0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({level, pressed, released} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 000000", {level, pressed, released});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({level, pressed, released} !== 6'b0) begin
      failures++;
      $display("FAIL reset_idle: got %b want 000000", {level, pressed, released});
    end
  endtask

  task automatic test_clean_press();
    int t = 0, nrel = 0, npr = 0, fall = 0;
    in_s[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (level[0]) begin t = k; break; end
    end
    checks++;
    if (t !== 6) begin failures++; $display("FAIL clean_rise_edge: got %0d want 6", t); end
    checks++;
    if (pressed[0] !== 1'b1) begin failures++; $display("FAIL clean_pressed_pulse: got %b want 1", pressed[0]); end
    tick();
    checks++;
    if (pressed[0] !== 1'b0) begin failures++; $display("FAIL clean_pressed_width: got %b want 0", pressed[0]); end
    in_s[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (released[0]) nrel++;
      if (pressed[0]) npr++;
      if (!level[0] && fall == 0) fall = k;
    end
    checks++;
    if (fall !== 6) begin failures++; $display("FAIL clean_fall_edge: got %0d want 6", fall); end
    checks++;
    if (nrel !== 1 || npr !== 0) begin
      failures++;
      $display("FAIL clean_release_pulses: got rel=%0d pr=%0d want rel=1 pr=0", nrel, npr);
    end
    settle();
  endtask

  task automatic test_bounce();
    int npr = 0, nrel = 0, t = 0;
    for (int i = 0; i < 10; i++) begin
      in_s[1] = ~in_s[1];
      tick(); if (pressed[1]) npr++; if (released[1]) nrel++;
      tick(); if (pressed[1]) npr++; if (released[1]) nrel++;
    end
    in_s[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (pressed[1]) npr++;
      if (released[1]) nrel++;
      if (level[1] && t == 0) t = k;
    end
    checks++;
    if (t !== 6) begin failures++; $display("FAIL bounce_rise_edge: got %0d want 6", t); end
    checks++;
    if (npr !== 1 || nrel !== 0) begin
      failures++;
      $display("FAIL bounce_pulses: got pr=%0d rel=%0d want pr=1 rel=0", npr, nrel);
    end
    settle();
  endtask

  task automatic test_autorepeat();
    int q[$];
    int nrel = 0, fall = 0, late = 0, bad = 0;
    in_s[0] = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (pressed[0]) q.push_back(k);
    end
    checks++;
    if (q.size() != 4 || q[0] != 6 || q[1] != 16 || q[2] != 19 || q[3] != 22) begin
      failures++;
      $display("FAIL repeat_edges: got %p want '{6,16,19,22}", q);
    end
    in_s[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if ({level, pressed, released} !== {e_lvl, e_p, e_r}) bad++;
      if (released[0]) nrel++;
      if (!level[0] && fall == 0) fall = k;
      if (fall != 0 && pressed[0]) late++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL repeat_release_model: got %0d mismatching cycles want 0", bad); end
    checks++;
    if (nrel !== 1 || late !== 0 || fall !== 6) begin
      failures++;
      $display("FAIL repeat_release: got rel=%0d late=%0d fall=%0d want 1 0 6", nrel, late, fall);
    end
    settle();
  endtask

  task automatic test_mask();
    int npr = 0;
    in_s[1] = 1'b1;
    repeat (40) begin
      tick();
      if (pressed[1]) npr++;
    end
    checks++;
    if (npr !== 1 || level[1] !== 1'b1) begin
      failures++;
      $display("FAIL mask_single_press: got pr=%0d lvl=%b want pr=1 lvl=1", npr, level[1]);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    in_s[0] = 1'b1;
    repeat (18) tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({level, pressed, released} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got %b want 000000", {level, pressed, released});
    end
    tick(); tick();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (level[0]) begin t = k; break; end
    end
    checks++;
    if (t !== 6 || pressed[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_held_press: got edge=%0d pr=%b want edge=6 pr=1", t, pressed[0]);
    end
    settle();
  endtask

  task automatic test_simultaneous();
    int t = 0, r0 = 0, r1 = 0;
    in_s = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (level != 2'b00) begin t = k; break; end
    end
    checks++;
    if (t !== 6 || level !== 2'b11 || pressed !== 2'b11) begin
      failures++;
      $display("FAIL simul_press: got edge=%0d lvl=%b pr=%b want 6 11 11", t, level, pressed);
    end
    in_s[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) in_s[0] = 1'b0;
      tick();
      if (released[0]) r0 = k;
      if (released[1]) r1 = k;
    end
    checks++;
    if (r1 !== 6 || r0 !== 8) begin
      failures++;
      $display("FAIL simul_release: got r0=%0d r1=%0d want r0=8 r1=6", r0, r1);
    end
    settle();
  endtask

  task automatic test_random();
    int bad = 0;
    repeat (150) begin
      in_s = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 9)) begin
        tick();
        checks++;
        if ({level, pressed, released} !== {e_lvl, e_p, e_r}) begin
          failures++;
          if (bad < 10)
            $display("FAIL random_model: got lvl=%b pr=%b rel=%b want lvl=%b pr=%b rel=%b",
                     level, pressed, released, e_lvl, e_p, e_r);
          bad++;
        end
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_mask();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
